// File: rtl/io_seq_gen_if.sv
// Pattern-source bus between io_seq_gen and its controller/pads.
// master = controller side (drives start/abort/hold), slave = io_seq_gen.
interface io_seq_gen_if #(
    parameter int WIDTH  = 8,
    parameter int HOLD_W = 16
);
    logic              start_i;
    logic              abort_i;
    logic [HOLD_W-1:0] hold_i;
    logic [WIDTH-1:0]  io_out;
    logic [WIDTH-1:0]  io_oeb;
    logic              busy_o;
    logic              done_o;

    modport master (
        output start_i, abort_i, hold_i,
        input  io_out, io_oeb, busy_o, done_o
    );

    modport slave (
        input  start_i, abort_i, hold_i,
        output io_out, io_oeb, busy_o, done_o
    );
endinterface

// File: rtl/io_seq_gen.sv
// IO-port test pattern source: 0x01..COUNT_LAST, 0xFF, 0x00, each value held H clocks.
// Define IO_SEQ_REPEAT_EN to loop passes continuously (H re-latched at each wrap).
module io_seq_gen #(
    parameter int WIDTH      = 8,
    parameter int HOLD_W     = 16,
    parameter int COUNT_LAST = 10
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    io_seq_gen_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_ONES  = 2'd2;
    localparam logic [1:0] ST_ZERO  = 2'd3;

    localparam logic [WIDTH-1:0]  VAL_FIRST = WIDTH'(1);
    localparam logic [WIDTH-1:0]  VAL_LAST  = WIDTH'(COUNT_LAST);
    localparam logic [WIDTH-1:0]  VAL_ONE   = WIDTH'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [1:0]        state_reg, state_next;
    logic [WIDTH-1:0]  value_reg, value_next;
    logic [HOLD_W-1:0] cnt_reg, cnt_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              done_reg, done_next;
    logic [WIDTH-1:0]  oeb_reg;

    logic [HOLD_W-1:0] hold_eff;
    logic              hold_end;

    // A programmed hold of zero still shows every value for one clock.
    assign hold_eff = (bus.hold_i == '0) ? HOLD_ONE : bus.hold_i;
    assign hold_end = (cnt_reg == (hold_reg - HOLD_ONE));

    always_comb begin
        state_next = state_reg;
        value_next = value_reg;
        cnt_next   = cnt_reg;
        hold_next  = hold_reg;
        done_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start_i) begin
                    hold_next  = hold_eff;
                    value_next = VAL_FIRST;
                    cnt_next   = '0;
                    state_next = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (hold_end) begin
                    cnt_next = '0;
                    if (value_reg == VAL_LAST) begin
                        value_next = '1;
                        state_next = ST_ONES;
                    end else begin
                        value_next = value_reg + VAL_ONE;
                    end
                end else begin
                    cnt_next = cnt_reg + HOLD_ONE;
                end
            end
            ST_ONES: begin
                if (hold_end) begin
                    cnt_next   = '0;
                    value_next = '0;
                    state_next = ST_ZERO;
                end else begin
                    cnt_next = cnt_reg + HOLD_ONE;
                end
            end
            ST_ZERO: begin
                if (hold_end) begin
                    cnt_next  = '0;
                    done_next = 1'b1;
`ifdef IO_SEQ_REPEAT_EN
                    hold_next  = hold_eff;
                    value_next = VAL_FIRST;
                    state_next = ST_COUNT;
`else
                    value_next = '0;
                    state_next = ST_IDLE;
`endif
                end else begin
                    cnt_next = cnt_reg + HOLD_ONE;
                end
            end
            default: begin
                value_next = '0;
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a start in the same cycle.
        if (bus.abort_i) begin
            state_next = ST_IDLE;
            value_next = '0;
            cnt_next   = '0;
            done_next  = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg <= ST_IDLE;
            value_reg <= '0;
            cnt_reg   <= '0;
            hold_reg  <= HOLD_ONE;
            done_reg  <= 1'b0;
            oeb_reg   <= '1;
        end else begin
            state_reg <= state_next;
            value_reg <= value_next;
            cnt_reg   <= cnt_next;
            hold_reg  <= hold_next;
            done_reg  <= done_next;
            oeb_reg   <= '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pad
            assign bus.io_out[gi] = value_reg[gi];
            assign bus.io_oeb[gi] = oeb_reg[gi];
        end
    endgenerate

    assign bus.busy_o = (state_reg != ST_IDLE);
    assign bus.done_o = done_reg;
endmodule

// File: doc/io_seq_gen.md
# io_seq_gen

User-project pattern source that drives mprj_io[7:0] with the IO-port test sequence 0x01, 0x02, … COUNT_LAST, then 0xFF, then 0x00, holding each value for a programmable number of clocks. It sits in the user project area behind the Caravel GPIO pads. It is the transmitting end of the IO-port check: an external monitor or bench waits for each value in order. Firmware or a logic-analyzer bit starts a pass; done_o reports completion.

## Interface
- WIDTH, 8: width of io_out / io_oeb.
- HOLD_W, 16: width of hold_i and the internal hold counter.
- COUNT_LAST, 10: last value of the counting phase; legal range 1..254.

- wb_clk_i  in  1  single clock, all logic on rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  level-sampled start request; acted on only in IDLE.
- abort_i  in  1  synchronous abort; returns to IDLE.
- hold_i  in  HOLD_W  cycles each value is held; latched on accepted start.
- io_out  out  WIDTH  pattern value to pads.
- io_oeb  out  WIDTH  pad output enables, active-low.
- busy_o  out  1  high while a pass is in progress.
- done_o  out  1  one-cycle pulse at end of pass.

## Operation
- States: IDLE, COUNT, ONES, ZERO.
- Effective hold H = hold_i latched at start, with 0 treated as 1.
- IDLE:
  - io_out = 0x00, busy_o = 0.
  - start_i = 1 and abort_i = 0: latch H, load io_out = 0x01, clear hold counter, go to COUNT.
- COUNT:
  - Each value is held for H cycles, then io_out increments.
  - After COUNT_LAST has been held H cycles: io_out = 0xFF, go to ONES.
- ONES: hold 0xFF for H cycles, then io_out = 0x00, go to ZERO.
- ZERO: hold 0x00 for H cycles, then go to IDLE and pulse done_o.
- Values are always 0x01..COUNT_LAST in order, each appearing exactly once; no skipped or repeated value.
- Any transition between values changes io_out in a single clock edge (all bits registered together).
- start_i while busy_o = 1 is ignored, and is not queued.
- abort_i (any state): next edge goes to IDLE, io_out = 0x00, hold counter cleared, no done_o. abort_i wins over start_i in the same cycle.
- hold_i changes mid-pass have no effect.
- Hold counter width HOLD_W; H up to 2^HOLD_W−1; no wrap within a hold.
- Reset values:
  - io_out = 0x00, io_oeb = all-ones, busy_o = 0, done_o = 0.
  - State IDLE, hold counter 0.
  - Reset mid-pass behaves identically, with no done_o.
- io_oeb: all-ones while wb_rst_i is high; all-zeros from the first edge after reset release, and it stays zero in every state.

## Timing
- start_i accepted at edge N:
  - io_out = 0x01 and busy_o = 1 from edge N onward.
  - Value k (1-based in the pass) is valid for cycles N+(k−1)·H through N+k·H−1.
- Pass length: (COUNT_LAST+2)·H cycles of busy_o = 1.
  - Default H=1 gives 12 cycles.
- done_o is high for exactly the one cycle after the last ZERO cycle.
  - busy_o = 0 in that cycle.
  - A start_i in that cycle is accepted; the new pass's 0x01 appears at the next edge.
- abort_i at edge M: busy_o = 0 and io_out = 0x00 from edge M.

## Configuration
- IO_SEQ_REPEAT_EN defined:
  - After ZERO, the block goes directly back to COUNT with io_out = 0x01; it does not enter IDLE.
  - done_o pulses for one cycle at each wrap, with busy_o staying 1.
  - Passes repeat until abort_i or reset.
  - H is re-latched from hold_i at each wrap.
- IO_SEQ_REPEAT_EN undefined: single pass as above; no re-latch.

## Test plan
- Reset held 5 cycles:
  - io_out=0x00, io_oeb=0xFF, busy_o=0 during reset.
  - io_oeb=0x00 on first edge after release.
- hold_i=0, start_i pulse:
  - io_out steps 01,02,…,0A,FF,00, one value per cycle.
  - busy_o high for 12 cycles; done_o single pulse in the 13th cycle.
- hold_i=3:
  - Each value held exactly 3 cycles; busy_o high for 36 cycles.
  - A start_i asserted during the pass has no effect.
- hold_i=4, abort_i raised in the cycle io_out=0x05 (with start_i high in the same cycle):
  - IDLE, io_out=0x00 next edge, no done_o, no new pass.
- Reset asserted mid-ONES: all outputs return to reset values next edge.
- IO_SEQ_REPEAT_EN defined, hold_i=1:
  - Two full passes with 0x00 followed directly by 0x01.
  - done_o pulses at each wrap, busy_o stays 1.
  - abort_i stops the sequence.
